// File: rtl/subparser_dispatcher.sv
// Subparser dispatcher: triggers one subparser per command, serves its FIFO reads, returns its Op_st.
// Latency cmd->trigger 1, done->op_valid 1, read->rd_done 2 cycles; cmd_ready stays low until the op is taken and the subparser is idle again.

package subparser_pkg;
    localparam int OP_CMD_BITS = 4;

    localparam logic [OP_CMD_BITS-1:0] CMD_G0  = 4'd0;
    localparam logic [OP_CMD_BITS-1:0] CMD_G1  = 4'd1;
    localparam logic [OP_CMD_BITS-1:0] CMD_G90 = 4'd2;
    localparam logic [OP_CMD_BITS-1:0] CMD_G91 = 4'd3;

    typedef struct packed {
        logic [OP_CMD_BITS-1:0] cmd;
        logic signed [15:0]     x;
        logic signed [15:0]     y;
        logic signed [15:0]     z;
        logic [15:0]            feed;
    } Op_st;
endpackage

module subparser_dispatcher
    import subparser_pkg::*;
#(
    parameter  int NUM_SUBPARSERS = 4,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int SEL_BITS       = (NUM_SUBPARSERS > 1) ? $clog2(NUM_SUBPARSERS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_en,

    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [OP_CMD_BITS-1:0]       cmd,
    input  logic [SEL_BITS-1:0]          sub_sel,

    output logic [OP_CMD_BITS-1:0]       sub_cmd,
    output logic [NUM_SUBPARSERS-1:0]    sub_trigger,
    input  logic [NUM_SUBPARSERS-1:0]    sub_rdy,
    input  logic [NUM_SUBPARSERS-1:0]    sub_done,
    input  Op_st [NUM_SUBPARSERS-1:0]    sub_op,
    input  logic [NUM_SUBPARSERS-1:0]    sub_rd_trigger,

    output logic                         rd_rdy,
    output logic                         rd_done,
    output logic                         is_empty,
    output logic [7:0]                   rd_char,

    output logic                         fifo_rd_en,
    input  logic [7:0]                   fifo_data,
    input  logic                         fifo_empty,

    output logic                         op_valid,
    input  logic                         op_ready,
    output Op_st                         op,
    output logic                         err
);

    localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIGGER,
        S_BUSY,
        S_OUTPUT,
        S_WAIT_RDY,
        S_ERROR
    } state_t;

    state_t                  state;
    logic [SEL_BITS-1:0]     sel_q;
    logic                    cmd_held;
    logic [TMO_BITS-1:0]     tmo_cnt;
    logic                    rd_pend;

    logic                    sel_in_range;
    logic                    sel_rdy;
    logic                    sel_done;
    logic                    sel_rd;
    logic                    rd_accept;
    logic                    tmo_hit;
    logic [NUM_SUBPARSERS-1:0] new_mask;
    logic [NUM_SUBPARSERS-1:0] sel_mask;

    assign sel_in_range = ({{(32-SEL_BITS){1'b0}}, sub_sel} < 32'(NUM_SUBPARSERS));
    assign new_mask     = NUM_SUBPARSERS'(1) << sub_sel;
    assign sel_mask     = NUM_SUBPARSERS'(1) << sel_q;

    assign sel_rdy      = sub_rdy[sel_q];
    assign sel_done     = sub_done[sel_q];
    assign sel_rd       = sub_rd_trigger[sel_q];

    // New reads are taken only while the selected subparser is running.
    assign rd_accept    = (state == S_BUSY) && sel_rd && rd_rdy;
    assign tmo_hit      = (tmo_cnt == TMO_BITS'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            sel_q       <= '0;
            cmd_held    <= 1'b0;
            tmo_cnt     <= '0;
            rd_pend     <= 1'b0;
            cmd_ready   <= 1'b1;
            sub_cmd     <= '0;
            sub_trigger <= '0;
            rd_rdy      <= 1'b1;
            rd_done     <= 1'b0;
            is_empty    <= 1'b0;
            rd_char     <= '0;
            fifo_rd_en  <= 1'b0;
            op_valid    <= 1'b0;
            op          <= '0;
            err         <= 1'b0;
        end else if (clk_en) begin
            // Two-stage read: pop (or detect empty), then report with rd_done.
            rd_done    <= 1'b0;
            fifo_rd_en <= 1'b0;
            rd_pend    <= 1'b0;
            if (rd_accept) begin
                rd_rdy     <= 1'b0;
                rd_pend    <= 1'b1;
                fifo_rd_en <= !fifo_empty;
            end
            if (rd_pend) begin
                rd_done  <= 1'b1;
                rd_rdy   <= 1'b1;
                is_empty <= !fifo_rd_en;
                if (fifo_rd_en) begin
                    rd_char <= fifo_data;
                end
            end

            case (state)
                S_IDLE: begin
                    if (cmd_held) begin
                        if (sel_rdy) begin
                            cmd_held    <= 1'b0;
                            sub_trigger <= sel_mask;
                            state       <= S_TRIGGER;
                        end
                    end else if (cmd_valid && cmd_ready) begin
                        sub_cmd   <= cmd;
                        sel_q     <= sub_sel;
                        err       <= 1'b0;
                        cmd_ready <= 1'b0;
                        if (!sel_in_range) begin
                            err   <= 1'b1;
                            state <= S_ERROR;
                        end else if (!sub_rdy[sub_sel]) begin
                            cmd_held <= 1'b1;
                        end else begin
                            sub_trigger <= new_mask;
                            state       <= S_TRIGGER;
                        end
                    end
                end

                S_TRIGGER: begin
                    if (!sel_rdy) begin
                        sub_trigger <= '0;
                        tmo_cnt     <= '0;
                        state       <= S_BUSY;
                    end
                end

                S_BUSY: begin
                    if (tmo_cnt != TMO_BITS'(TIMEOUT_CYCLES)) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                    if (sel_done) begin
                        op       <= sub_op[sel_q];
                        op_valid <= rd_rdy && !rd_accept;
                        state    <= S_OUTPUT;
                    end else if (tmo_hit) begin
                        err   <= 1'b1;
                        state <= S_ERROR;
                    end
                end

                // op_valid is withheld until any in-flight read has completed.
                S_OUTPUT: begin
                    if (!op_valid) begin
                        if (rd_rdy) begin
                            op_valid <= 1'b1;
                        end
                    end else if (op_ready) begin
                        op_valid <= 1'b0;
                        state    <= S_WAIT_RDY;
                    end
                end

                S_WAIT_RDY: begin
                    if (sel_rdy) begin
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                S_ERROR: begin
                    sub_trigger <= '0;
                    cmd_ready   <= 1'b1;
                    state       <= S_IDLE;
                end

                default: begin
                    sub_trigger <= '0;
                    cmd_ready   <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/subparser_dispatcher.md
# subparser_dispatcher

Master side of the subparser handshake. Accepts a decoded command plus a subparser index from the line decoder and triggers the selected subparser. It serves that subparser's character reads from the line character FIFO, collects the produced `Op_st`, and hands it to the position keeper/motion stage over a valid/ready pair. It sits between the G-code line decoder and the bank of subparsers, including the dummy G90/G91 subparser.

## Interface
- `NUM_SUBPARSERS`, 4: number of attached subparsers; index width `SEL_BITS = $clog2(NUM_SUBPARSERS)`.
- `TIMEOUT_CYCLES`, 1024: enabled cycles allowed between trigger acceptance and `done` before abort.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `clk_en`  in  1  state advances only when high.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  dispatcher can accept a command.
- `cmd`  in  `OP_CMD_BITS`  command forwarded to the subparser.
- `sub_sel`  in  `SEL_BITS`  target subparser.
- `sub_cmd`  out  `OP_CMD_BITS`  latched command, common to all subparsers.
- `sub_trigger`  out  `NUM_SUBPARSERS`  one-hot trigger.
- `sub_rdy`  in  `NUM_SUBPARSERS`  subparser idle.
- `sub_done`  in  `NUM_SUBPARSERS`  op valid pulse.
- `sub_op`  in  `NUM_SUBPARSERS` x `Op_st`  subparser outputs.
- `sub_rd_trigger`  in  `NUM_SUBPARSERS`  character read request.
- `rd_rdy`, `rd_done`, `is_empty`  out  1 each  read channel, common to all subparsers.
- `rd_char`  out  8  character returned.
- `fifo_rd_en`  out  1  pop.
- `fifo_data`  in  8  FIFO head.
- `fifo_empty`  in  1.
- `op_valid`  out  1.
- `op_ready`  in  1.
- `op`  out  `Op_st`.
- `err`  out  1  sticky error; cleared by the next accepted command.

## Operation
- Reset values:
  - All outputs 0 except `rd_rdy`=1 and `cmd_ready`=1.
  - `op` is zero.
  - State is IDLE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch `cmd`/`sub_sel` and clear `err`.
  - If `sub_sel` ≥ `NUM_SUBPARSERS`, go to ERROR.
  - If `sub_rdy[sel]`=0, stay in IDLE with `cmd_ready`=0 until it rises.
  - Otherwise go to TRIGGER.
- TRIGGER:
  - Hold `sub_trigger[sel]`=1.
  - When `sub_rdy[sel]` falls, drop the trigger and go to BUSY.
- BUSY:
  - Serve the read channel.
  - On `sub_done[sel]`, latch `sub_op[sel]` into `op` and go to OUTPUT.
  - If the timeout counter reaches `TIMEOUT_CYCLES`, go to ERROR.
- OUTPUT:
  - `op_valid`=1 until `op_ready`.
  - Then go to WAIT_RDY.
- WAIT_RDY:
  - Wait for `sub_rdy[sel]`=1, then go to IDLE.
- ERROR:
  - Set `err`=1, drop all triggers, pulse nothing.
  - Go to IDLE in the next cycle.
- Read channel (BUSY only; requests from unselected subparsers are ignored):
  - On `sub_rd_trigger[sel]` with `rd_rdy`=1, set `rd_rdy`=0.
  - If `fifo_empty`: next cycle `is_empty`=1, `rd_done` pulses 1 cycle, `rd_rdy`=1.
  - Else: `fifo_rd_en` pulses 1 cycle and `rd_char` latches `fifo_data` in the same cycle. Next cycle `is_empty`=0, `rd_done` pulse, `rd_rdy`=1.
  - `is_empty` and `rd_char` hold until the next read.
- `sub_done` arriving while a read is in flight: `op` is still captured and the read completes normally. The OUTPUT state waits for `rd_rdy`=1 before asserting `op_valid`.
- Timeout counter:
  - Clears on entry to BUSY.
  - Saturates and does not wrap.
  - Reads do not reset it.

## Timing
- `clk_en`=0 freezes the state, counters and pulse outputs. A pending `rd_done` or `fifo_rd_en` pulse is held until the next enabled cycle.
- Latency:
  - `cmd_valid` to `sub_trigger`: 1 enabled cycle.
  - `sub_done` to `op_valid`: 1 cycle.
  - Read request to `rd_done`: 2 cycles.
- `sub_trigger` is a level, never a pulse. It is guaranteed to stay high until the falling edge of `rdy` is observed.
- Asserting `reset` mid-operation:
  - Immediately clears triggers, `op_valid` and `fifo_rd_en`.
  - No FIFO pop is issued after reset assertion.
- Simultaneous `op_ready` and `sub_rdy` rising: OUTPUT goes to WAIT_RDY, then to IDLE in the next cycle (no skip).

## Test plan
- Reset, then `cmd`=G91, `sub_sel`=0. A dummy subparser drops `rdy` after 2 cycles and pulses `done` with `op.cmd`=G91 → `sub_trigger`=0001 for exactly those cycles; `op_valid` with `op.cmd`=G91; `cmd_ready` returns after `rdy` rises.
- Back-to-back G91 then G90 on index 0 with `op_ready` tied 1 → two ops output in order; the second trigger only after `rdy` has risen again.
- Subparser 2 reads 3 characters with FIFO holding "X1" → `rd_char`='X', '1' with `is_empty`=0, then the third read gives `is_empty`=1; exactly 2 `fifo_rd_en` pulses.
- Index 3 asserts `sub_rd_trigger` while index 1 is selected → no `fifo_rd_en`, `rd_rdy` stays 1.
- Subparser never asserts `done`, `TIMEOUT_CYCLES`=16 → `err`=1 at 16 cycles after BUSY entry, trigger low, back to IDLE. The next command clears `err`.
- `reset` asserted during OUTPUT with `op_ready`=0 → `op_valid`=0 asynchronously, `cmd_ready`=1, `rd_rdy`=1.
